// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared types and constants for the LED blink sequencer.
// Holds the controller state encoding, the 4-bit count/period widths and
// the default prescaler divide ratio. No ports.
package led_seq_pkg;

  localparam int CNT_W        = 4;   // blink count width
  localparam int PER_W        = 4;   // phase length code width
  localparam int TICK_DIV_DEF = 16;  // default clock cycles per tick

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_DONE = 2'd3
  } led_state_e;

endpackage

// File: rtl/led_seq_tick.sv
// led_seq_tick: free-running prescaler that produces one tick every TICK_DIV
// enabled cycles. Counts 0..TICK_DIV-1 and wraps; tick is high while the count
// sits at TICK_DIV-1 and enable is high.
// Ports: m_clock, p_reset (sync, active-high), clear (restart at 0),
//        enable (advance), tick (terminal-count strobe).
module led_seq_tick #(
  parameter int TICK_DIV = 16
) (
  input  logic m_clock,
  input  logic p_reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int             CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] pre_cnt;

  always_ff @(posedge m_clock) begin
    if (p_reset || clear) begin
      pre_cnt <= '0;
    end else if (enable) begin
      pre_cnt <= (pre_cnt == LAST) ? '0 : pre_cnt + CW'(1);
    end
  end

  assign tick = enable & (pre_cnt == LAST);

endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: accepts blink commands (count, phase length) over a
// valid/ready handshake and drives an LED through ON/OFF phases, each lasting
// (period+1)*TICK_DIV cycles, then pulses done for one cycle.
// Ports: m_clock, p_reset (sync, active-high); req_valid/req_ready/req_count/
//        req_period command input; led, busy, remaining, done status outputs;
//        abort (only when LED_SEQ_ABORT_EN is defined) cancels the active command.
// Optional feature macro: LED_SEQ_ABORT_EN.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic             m_clock,
  input  logic             p_reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_count,
  input  logic [PER_W-1:0] req_period,
  output logic             led,
  output logic             busy,
  output logic [CNT_W-1:0] remaining,
  output logic             done
`ifdef LED_SEQ_ABORT_EN
  ,
  input  logic             abort
`endif
);

  led_state_e       state_q;
  led_state_e       state_d;
  logic [PER_W-1:0] period_q;
  logic [PER_W-1:0] phase_cnt;
  logic             tick;
  logic             xfer;
  logic             phase_end;
  logic             phase_clr;
  logic             tick_en;
  logic             abort_hit;
  logic             led_d;
  logic             busy_d;
  logic             done_d;
  logic [CNT_W-1:0] remaining_d;

  assign req_ready = (state_q == ST_IDLE);
  assign xfer      = req_valid & req_ready;
  assign tick_en   = (state_q == ST_ON) || (state_q == ST_OFF);

  // A phase ends on the tick that completes its (period+1)-th tick.
  assign phase_end = tick && (phase_cnt == period_q);

  // Every state change is a phase entry: restart both timing counters.
  assign phase_clr = (state_d != state_q);

`ifdef LED_SEQ_ABORT_EN
  assign abort_hit = abort & tick_en;
`else
  assign abort_hit = 1'b0;
`endif

  led_seq_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .clear   (phase_clr),
    .enable  (tick_en),
    .tick    (tick)
  );

  // State register
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          state_d = (req_count == '0) ? ST_DONE : ST_ON;
        end
      end
      ST_ON: begin
        if (abort_hit) begin
          state_d = ST_DONE;
        end else if (phase_end) begin
          state_d = ST_OFF;
        end
      end
      ST_OFF: begin
        if (abort_hit) begin
          state_d = ST_DONE;
        end else if (phase_end) begin
          state_d = (remaining != '0) ? ST_ON : ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: decode the next state so the registered outputs line up
  // with the state they describe.
  always_comb begin
    led_d       = (state_d == ST_ON);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    remaining_d = remaining;
    if (xfer) begin
      remaining_d = (req_count == '0) ? '0 : req_count - CNT_W'(1);
    end else if (abort_hit) begin
      remaining_d = '0;
    end else if ((state_q == ST_OFF) && phase_end && (remaining != '0)) begin
      remaining_d = remaining - CNT_W'(1);
    end
  end

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      led       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
    end else begin
      led       <= led_d;
      busy      <= busy_d;
      done      <= done_d;
      remaining <= remaining_d;
    end
  end

  // Command latch and tick-within-phase counter. The counter never exceeds
  // period_q because reaching it ends the phase and clears it.
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      period_q  <= '0;
      phase_cnt <= '0;
    end else begin
      if (xfer) begin
        period_q <= req_period;
      end
      if (phase_clr) begin
        phase_cnt <= '0;
      end else if (tick) begin
        phase_cnt <= phase_cnt + PER_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: directed bench for led_seq_ctrl with TICK_DIV=4.
// Cycle c of a command is the cycle that follows the c-th rising edge after
// the cycle in which the command was presented with req_ready high.
module tb_led_seq_ctrl;

  localparam int TD = 4;

  logic       m_clock = 1'b0;
  logic       p_reset;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_count;
  logic [3:0] req_period;
  logic       led;
  logic       busy;
  logic [3:0] remaining;
  logic       done;
`ifdef LED_SEQ_ABORT_EN
  logic       abort;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 m_clock = ~m_clock;

  led_seq_ctrl #(
    .TICK_DIV (TD)
  ) dut (
    .m_clock    (m_clock),
    .p_reset    (p_reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_count  (req_count),
    .req_period (req_period),
    .led        (led),
    .busy       (busy),
    .remaining  (remaining),
    .done       (done)
`ifdef LED_SEQ_ABORT_EN
    ,
    .abort      (abort)
`endif
  );

  task automatic step();
    @(posedge m_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Steps through cycles first..last of a command (cnt, per) and compares all
  // outputs with the ideal waveform: alternating ON/OFF phases of p_len
  // cycles starting in cycle 1, done in the cycle after the last OFF phase.
  task automatic run_cmd(input int cnt, input int per, input int first,
                         input int last, input bit keep);
    int p_len;
    int done_c;
    int e_led;
    int e_rem;
    p_len  = (per + 1) * TD;
    done_c = 2 * cnt * p_len + 1;
    for (int c = first; c <= last; c++) begin
      step();
      if (!keep) req_valid = 1'b0;
      e_led = ((c < done_c) && ((((c - 1) / p_len) % 2) == 0)) ? 1 : 0;
      e_rem = (c < done_c) ? (cnt - 1 - ((c - 1) / (2 * p_len))) : 0;
      check($sformatf("led c%0d n%0d p%0d", c, cnt, per), 32'(led), 32'(e_led));
      check($sformatf("remaining c%0d n%0d p%0d", c, cnt, per), 32'(remaining), 32'(e_rem));
      check($sformatf("done c%0d n%0d p%0d", c, cnt, per), 32'(done), (c == done_c) ? 32'd1 : 32'd0);
      check($sformatf("busy c%0d n%0d p%0d", c, cnt, per), 32'(busy), (c <= done_c) ? 32'd1 : 32'd0);
      check($sformatf("req_ready c%0d n%0d p%0d", c, cnt, per), 32'(req_ready), (c > done_c) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic issue(input int cnt, input int per);
    req_valid  = 1'b1;
    req_count  = 4'(cnt);
    req_period = 4'(per);
  endtask

  initial begin
    p_reset    = 1'b1;
    req_valid  = 1'b0;
    req_count  = 4'd0;
    req_period = 4'd0;
`ifdef LED_SEQ_ABORT_EN
    abort      = 1'b0;
`endif
    step();
    step();
    check("reset led", 32'(led), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset remaining", 32'(remaining), 32'd0);
    p_reset = 1'b0;
    step();
    check("idle req_ready", 32'(req_ready), 32'd1);

    // Two blinks, period code 1: 8-cycle phases, done in cycle 33.
    issue(2, 1);
    run_cmd(2, 1, 1, 34, 1'b0);

    // Zero blinks: straight to done in cycle 1, LED never lights.
    issue(0, 0);
    run_cmd(0, 0, 1, 2, 1'b0);

    // Request held through execution: first command unaffected, second
    // (3 blinks, period 2) taken on the first idle cycle.
    issue(1, 0);
    run_cmd(1, 0, 1, 1, 1'b1);
    req_count  = 4'd3;
    req_period = 4'd2;
    run_cmd(1, 0, 2, 10, 1'b1);
    run_cmd(3, 2, 1, 74, 1'b0);

    // Reset in cycle 12 of a 3-blink command.
    issue(3, 1);
    run_cmd(3, 1, 1, 12, 1'b0);
    p_reset = 1'b1;
    step();
    p_reset = 1'b0;
    check("midreset led", 32'(led), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset remaining", 32'(remaining), 32'd0);
    check("midreset req_ready", 32'(req_ready), 32'd1);
    check("midreset done", 32'(done), 32'd0);
    for (int i = 0; i < 40; i++) begin
      step();
      check($sformatf("postreset done i%0d", i), 32'(done), 32'd0);
      check($sformatf("postreset busy i%0d", i), 32'(busy), 32'd0);
    end

    // Longest phase code: 64-cycle phases, no counter overflow.
    issue(1, 15);
    run_cmd(1, 15, 1, 130, 1'b0);

`ifdef LED_SEQ_ABORT_EN
    // Abort in cycle 5 (OFF phase) of a 4-blink, period 0 command.
    issue(4, 0);
    run_cmd(4, 0, 1, 5, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort done", 32'(done), 32'd1);
    check("abort led", 32'(led), 32'd0);
    check("abort remaining", 32'(remaining), 32'd0);
    check("abort busy", 32'(busy), 32'd1);
    step();
    check("abort idle req_ready", 32'(req_ready), 32'd1);
    check("abort idle done", 32'(done), 32'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort in idle busy", 32'(busy), 32'd0);
    check("abort in idle done", 32'(done), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
